// File: rtl/mult8_prod_accum.sv
// Packet accumulator for 16-bit multiplier products with a valid/ready result port.
// Optional macro MAC_SATURATE_EN: clamp the sum at 2^ACC_W-1 instead of wrapping.
module mult8_prod_accum #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               accept;
  logic [ACC_W:0]     sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    in_ready = (state_q != S_HOLD);
    accept   = in_valid & in_ready;
    // one extra bit so the carry-out is visible for overflow detection
    sum = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};

    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) begin
`ifdef MAC_SATURATE_EN
          acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
          acc_d = sum[ACC_W-1:0];
`endif
          ovf_d   = ovf_q | sum[ACC_W];
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          state_d = in_last ? S_HOLD : S_ACCUM;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_valid = (state_q == S_HOLD);
  assign out_acc   = acc_q;
  assign out_cnt   = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mult8_prod_accum.sv
// Directed self-checking bench for mult8_prod_accum (honours MAC_SATURATE_EN).
module tb_mult8_prod_accum;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_prod;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_acc;
  logic [7:0]  out_cnt;
  logic        out_ovf;

  int unsigned total;
  int unsigned bad;

  mult8_prod_accum #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic r,
                         input logic [23:0] acc, input logic [7:0] cnt, input logic ovf);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(r));
    chk({tag, ".out_acc"},   32'(out_acc),   32'(acc));
    chk({tag, ".out_cnt"},   32'(out_cnt),   32'(cnt));
    chk({tag, ".out_ovf"},   32'(out_ovf),   32'(ovf));
  endtask

  // present one beat, let one edge pass, sample 1ns later
  task automatic beat(input logic [15:0] p, input logic last);
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: build partial state, then assert reset mid-cycle with no clock edge
    beat(16'h0042, 1'b0);
    chk_all("pre_rst", 1'b0, 1'b1, 24'h000042, 8'd1, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 1'b1, 24'h0, 8'd0, 1'b0);
    #1 rst = 1'b0;
    idle_cycle();

    // 2: three beats, result after last, back to IDLE next edge
    out_ready = 1'b1;
    beat(16'h0001, 1'b0);
    chk_all("t2_b1", 1'b0, 1'b1, 24'h000001, 8'd1, 1'b0);
    beat(16'h00FF, 1'b0);
    beat(16'hFFFF, 1'b1);
    chk_all("t2_res", 1'b1, 1'b0, 24'h0100FF, 8'd3, 1'b0);
    idle_cycle();
    chk_all("t2_idle", 1'b0, 1'b1, 24'h0, 8'd0, 1'b0);

    // 3: single last beat from IDLE
    out_ready = 1'b0;
    beat(16'h1234, 1'b1);
    chk_all("t3_res", 1'b1, 1'b0, 24'h001234, 8'd1, 1'b0);

    // 4: stall with in_valid held high; nothing absorbed
    in_valid = 1'b1; in_prod = 16'h7777; in_last = 1'b0;
    for (int i = 0; i < 5; i++) idle_cycle();
    chk_all("t4_stall", 1'b1, 1'b0, 24'h001234, 8'd1, 1'b0);
    out_ready = 1'b1;
    idle_cycle();
    chk_all("t4_release", 1'b0, 1'b1, 24'h0, 8'd0, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b0;

    // 5: 257 beats of 0xFFFF: count saturates, carry on the 257th
    for (int i = 1; i <= 256; i++) beat(16'hFFFF, 1'b0);
    chk_all("t5_256", 1'b0, 1'b1, 24'hFFFF00, 8'hFF, 1'b0);
    beat(16'hFFFF, 1'b1);
`ifdef MAC_SATURATE_EN
    chk_all("t5_res", 1'b1, 1'b0, 24'hFFFFFF, 8'hFF, 1'b1);
`else
    chk_all("t5_res", 1'b1, 1'b0, 24'h00FEFF, 8'hFF, 1'b1);
`endif
    out_ready = 1'b1;
    idle_cycle();
    chk_all("t5_clear", 1'b0, 1'b1, 24'h0, 8'd0, 1'b0);
    out_ready = 1'b0;

    // 6: reset mid-packet discards partial, next packet starts clean
    beat(16'h0010, 1'b0);
    beat(16'h0010, 1'b0);
    chk_all("t6_part", 1'b0, 1'b1, 24'h000020, 8'd2, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk_all("t6_rst", 1'b0, 1'b1, 24'h0, 8'd0, 1'b0);
    idle_cycle();
    rst = 1'b0;
    beat(16'h0005, 1'b1);
    chk_all("t6_res", 1'b1, 1'b0, 24'h000005, 8'd1, 1'b0);

    // reset while a result is pending drops it
    #3 rst = 1'b1;
    #1;
    chk_all("hold_rst", 1'b0, 1'b1, 24'h0, 8'd0, 1'b0);
    idle_cycle();
    rst = 1'b0;
    idle_cycle();
    chk_all("hold_rst_after", 1'b0, 1'b1, 24'h0, 8'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
